// File: rtl/serial_deser_pkg.sv
// Shared types and frame constants for the serial deserializer.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Ceiling log2; callers size the bit counter with clog2(WIDTH+1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// MSB-first shift register with running even parity of the shifted bits.
module deser_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             si,
  output logic [WIDTH-1:0] word,
  output logic             parity
);

  logic [WIDTH-1:0] word_q;
  logic             parity_q;

  // Clear at frame start, otherwise shift one bit and fold it into the parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '0;
      parity_q <= 1'b0;
    end else if (clear) begin
      word_q   <= '0;
      parity_q <= 1'b0;
    end else if (shift_en) begin
      word_q   <= {word_q[WIDTH-2:0], si};
      parity_q <= parity_q ^ si;
    end
  end

  assign word   = word_q;
  assign parity = parity_q;

endmodule

// File: rtl/serial_deser.sv
// Serial frame receiver: start, WIDTH data bits MSB first, even parity, stop.
// Delivers words through a one-entry valid/ready buffer with error pulses.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rx_par_q, rx_par_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;

  logic             clear_c;
  logic             shift_en_c;
  logic [WIDTH-1:0] word;
  logic             parity;

  deser_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_c),
    .shift_en (shift_en_c),
    .si       (si),
    .word     (word),
    .parity   (parity)
  );

  // State, counter, output buffer and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rx_par_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_par_q     <= rx_par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state, frame evaluation and buffer handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_par_d     = rx_par_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overflow_d   = 1'b0;
    clear_c      = 1'b0;
    shift_en_c   = 1'b0;

    // Consumer drains the buffer; a load on the same edge overrides below.
    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (si == START_BIT) begin
          clear_c = 1'b1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        shift_en_c = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        rx_par_d = si;
        state_d  = STOP;
      end
      STOP: begin
        state_d = IDLE;
        if (si != STOP_BIT) begin
          frame_err_d = 1'b1;
        end else if (rx_par_q != parity) begin
          parity_err_d = 1'b1;
        end else if (!data_valid_q || data_ready) begin
          data_out_d   = word;
          data_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: directed frames then random traffic,
// compared every cycle against a frame-level bit-queue reference model.
module tb_serial_deser;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         si;
  logic         data_ready;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         parity_err;
  logic         frame_err;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the frame in flight, buffer contents, expected pulses.
  logic         m_bits[$];
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         e_perr, e_ferr, e_ovf;

  serial_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level behaviour: collect start..stop bits, then judge the whole frame.
  task automatic model(input logic r, input logic s, input logic rdy);
    logic         fire;
    logic         loaded;
    logic [W-1:0] d;
    e_perr = 1'b0;
    e_ferr = 1'b0;
    e_ovf  = 1'b0;
    if (r) begin
      m_bits.delete();
      m_data  = '0;
      m_valid = 1'b0;
    end else begin
      fire   = m_valid && rdy;
      loaded = 1'b0;
      if (m_bits.size() != 0 || s) m_bits.push_back(s);
      if (m_bits.size() == W + 3) begin
        d = '0;
        for (int i = 1; i <= W; i++) d = {d[W-2:0], m_bits[i]};
        if (m_bits[W+2] == 1'b1) e_ferr = 1'b1;
        else if ((^d) != m_bits[W+1]) e_perr = 1'b1;
        else if (!m_valid || rdy) begin
          m_data  = d;
          m_valid = 1'b1;
          loaded  = 1'b1;
        end else e_ovf = 1'b1;
        m_bits.delete();
      end
      if (fire && !loaded) m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rdy);
    @(negedge clk);
    rst        = r;
    si         = s;
    data_ready = rdy;
    @(posedge clk);
    #1;
    model(r, s, rdy);
    chk("data_out",   32'(data_out),   32'(m_data));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("parity_err", 32'(parity_err), 32'(e_perr));
    chk("frame_err",  32'(frame_err),  32'(e_ferr));
    chk("overflow",   32'(overflow),   32'(e_ovf));
  endtask

  // rmode: 0 never ready, 1 ready only on stop bit, 2 random, 3 always.
  function automatic logic rsel(input int rmode, input bit at_stop);
    case (rmode)
      0:       return 1'b0;
      1:       return at_stop ? 1'b1 : 1'b0;
      2:       return logic'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  task automatic frame(input logic [W-1:0] d, input logic par, input logic stop, input int rmode);
    step(1'b0, 1'b1, rsel(rmode, 1'b0));
    for (int i = W - 1; i >= 0; i--) step(1'b0, d[i], rsel(rmode, 1'b0));
    step(1'b0, par, rsel(rmode, 1'b0));
    step(1'b0, stop, rsel(rmode, 1'b1));
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rp;
    logic         rs;
    int           kind;
    rst        = 1'b1;
    si         = 1'b0;
    data_ready = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Good frame 0xA5, valid on edge 10, then consume
    frame(8'hA5, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Parity error on 0x01
    frame(8'h01, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);

    // Frame error on 0x3C, then line idle keeps receiver idle
    frame(8'h3C, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Back-to-back 0x11, 0x22 with no consumer: overflow on second
    frame(8'h11, 1'b0, 1'b0, 0);
    frame(8'h22, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Buffer full, consumer ready exactly on the stop edge: replace, no overflow
    frame(8'h11, 1'b0, 1'b0, 0);
    frame(8'h22, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-frame at data bit 4, then a full 0x5A frame
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    frame(8'h5A, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic with random gaps, errors and consumer readiness
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, rsel(2, 1'b0));
      rd   = W'($urandom);
      kind = int'($urandom_range(0, 5));
      rp   = ^rd;
      rs   = 1'b0;
      if (kind == 0) rp = ~rp;
      if (kind == 1) rs = 1'b1;
      frame(rd, rp, rs, 2);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of data bits per frame (range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; the reset is synchronous and active-high.
REQ-004 SHALL have port: si  input  1  serial line, one bit sampled per clk; idle level 0.
REQ-005 SHALL have port: data_out  output  WIDTH  last accepted frame payload.
REQ-006 SHALL have port: data_valid  output  1  data_out holds an unconsumed word.
REQ-007 SHALL have port: data_ready  input  1  consumer accepts word when data_valid & data_ready.
REQ-008 SHALL have port: parity_err  output  1  one-cycle pulse, frame dropped for bad parity.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse, frame dropped for bad stop bit.
REQ-010 SHALL have port: overflow  output  1  one-cycle pulse, good frame dropped, buffer full.

Function
REQ-011 SHALL receive frames of: start bit 1, WIDTH data bits MSB first, even-parity bit (XOR of data bits), stop bit 0.
REQ-012 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: si=1 -> DATA with bit counter cleared; si=0 -> remain IDLE.
REQ-014 DATA: shift si into shift register each cycle; after WIDTH-th bit -> PARITY.
REQ-015 PARITY: capture si as received parity -> STOP.
REQ-016 STOP: evaluate frame on this edge -> IDLE unconditionally; stop bit 1 is not reinterpreted as a start bit.
REQ-017 Evaluation priority: stop bit 1 -> frame_err; else parity mismatch -> parity_err; else load or overflow per REQ-018..020.
REQ-018 Good frame with buffer empty, or buffer full and data_ready=1 on the same edge: load data_out, data_valid=1 on that edge.
REQ-019 Good frame with data_valid=1 and data_ready=0: discard frame, data_out unchanged, overflow pulse.
REQ-020 data_valid & data_ready with no load on that edge: data_valid clears; data_out holds its value.
REQ-021 Latency: data_valid rises on edge WIDTH+2 after the start-bit sampling edge (start edge = 0).
REQ-022 Error/overflow pulses SHALL be registered, high exactly one cycle, at most one of the three per frame.
REQ-023 data_ready while data_valid=0 SHALL have no effect.
REQ-024 Back-to-back frames (start bit on cycle immediately after stop) SHALL be received without gap.

Reset
REQ-025 rst=1 on an edge SHALL force: state IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, overflow 0.
REQ-026 rst mid-frame SHALL discard the partial frame; no error pulse results.
REQ-027 rst SHALL take priority over every other event on the same edge.

Structure
REQ-028 Shared package SHALL hold the FSM state enum, frame constants START_BIT=1, STOP_BIT=0, and counter width function clog2(WIDTH+1).
REQ-029 Shift register plus running parity SHALL be one sub-module, deser_shift_reg (clk, rst, clear, shift_en, si, word, parity).
REQ-030 FSM, output buffer and pulse generation SHALL live in serial_deser.

Verification (WIDTH=8)
REQ-031 si: 1, 1010_0101, 0, 0 -> data_out=0xA5, data_valid high on edge 10 after start edge, no error pulses.
REQ-032 si: 1, 0x01 bits, parity 0, stop 0 -> parity_err pulses 1 cycle on edge 10, data_valid stays 0.
REQ-033 si: 1, 0x3C bits, parity 0, stop 1 -> frame_err pulse, FSM in IDLE, following cycle si=0 keeps IDLE.
REQ-034 two good frames 0x11, 0x22 back-to-back, data_ready=0 -> data_out=0x11 held, overflow pulse at second stop edge; then data_ready=1 one cycle -> data_valid=0.
REQ-035 buffer holds 0x11, data_ready=1 on exactly the stop edge of frame 0x22 -> data_out=0x22, data_valid stays 1, no overflow.
REQ-036 rst=1 for one cycle at data bit 4 of a frame, then full frame 0x5A -> only 0x5A delivered, no error pulses.
